// File: rtl/uart_tx_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_pkg
// Shared definitions for the UART transmitter: the 3-bit FSM state encoding,
// the parity-mode constants and a helper that computes the parity line bit.
// No ports (package).
// ---------------------------------------------------------------------------
package uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Even parity sends the XOR of the data bits; odd parity sends its inverse.
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        return (mode == PARITY_EVEN) ? ^data : ~^data;
    endfunction

endpackage

// File: rtl/uart_tx_baud_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_gen
// Bit-time counter for the UART transmitter. Counts clocks within one line
// bit and raises bit_done_o for one cycle on the last clock of the bit.
// Ports:
//   clk        - rising-edge clock
//   reset      - synchronous active-high reset
//   clear_i    - restart counting from 0 on the next cycle
//   bit_done_o - one-cycle tick on the final clock of a bit time
// ---------------------------------------------------------------------------
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    output logic bit_done_o
);

    localparam int CNT_W = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_done_o = (cnt_q == LAST);

    // The counter wraps to 0 on its own at the end of each bit, so a bit time
    // never exceeds CLKS_PER_BIT clocks even without a clear.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear_i || bit_done_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// UART transmitter that pops bytes from an upstream FIFO and serialises them
// as start bit, 8 data bits LSB first, optional parity bit and 1 or 2 stop
// bits.
// Parameters: CLK_FREQ (Hz), BIT_RATE (bit/s), PARITY (0 none/1 odd/2 even),
//             STOP_BITS (1 or 2).
// Ports:
//   clk        - rising-edge clock
//   reset      - synchronous active-high reset
//   enable     - allows new frames to start while high
//   fifo_empty - upstream FIFO empty flag
//   fifo_data  - upstream FIFO head word
//   fifo_read  - one-cycle pop strobe to the FIFO
//   tx         - serial line, idle high
//   busy       - high whenever a frame is in progress
// ---------------------------------------------------------------------------
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLK_FREQ  = 25000000,
    parameter int BIT_RATE  = 9600,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_read,
    output logic       tx,
    output logic       busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BIT_RATE;

    if (CLKS_PER_BIT < 2) begin : g_bad_rate
        $error("uart_tx: CLK_FREQ/BIT_RATE must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (PARITY < PARITY_NONE || PARITY > PARITY_EVEN) begin : g_bad_parity
        $error("uart_tx: PARITY must be 0, 1 or 2");
    end

    state_e     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic       parity_q, parity_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       stop_idx_q, stop_idx_d;
    logic       baud_clear;
    logic       bit_done;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (baud_clear),
        .bit_done_o(bit_done)
    );

    assign busy = (state_q != ST_IDLE);

    // Next-state and output logic. The baud counter is cleared on every state
    // change (and held clear in IDLE) so each state starts a fresh bit time.
    // The pop is gated by reset so a reset in the pop cycle never consumes
    // a byte.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        fifo_read  = 1'b0;
        tx         = 1'b1;
        baud_clear = 1'b0;

        case (state_q)
            ST_IDLE: begin
                baud_clear = 1'b1;
                bit_idx_d  = 3'd0;
                stop_idx_d = 1'b0;
                if (enable && !fifo_empty && !reset) begin
                    fifo_read = 1'b1;
                    shift_d   = fifo_data;
                    parity_d  = parity_bit(fifo_data, PARITY);
                    state_d   = ST_START;
                end
            end

            ST_START: begin
                tx = 1'b0;
                if (bit_done) begin
                    state_d    = ST_DATA;
                    bit_idx_d  = 3'd0;
                    baud_clear = 1'b1;
                end
            end

            ST_DATA: begin
                tx = shift_q[0];
                if (bit_done) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d    = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        bit_idx_d  = 3'd0;
                        baud_clear = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end

            ST_PARITY: begin
                tx = parity_q;
                if (bit_done) begin
                    state_d    = ST_STOP;
                    baud_clear = 1'b1;
                end
            end

            ST_STOP: begin
                tx = 1'b1;
                if (bit_done) begin
                    // A second stop bit stays in STOP; the baud counter wraps
                    // by itself so no clear is needed between the two.
                    if (STOP_BITS == 2 && stop_idx_q == 1'b0) begin
                        stop_idx_d = 1'b1;
                    end else begin
                        state_d    = ST_IDLE;
                        stop_idx_d = 1'b0;
                        baud_clear = 1'b1;
                    end
                end
            end

            default: begin
                state_d    = ST_IDLE;
                baud_clear = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= 8'h00;
            parity_q   <= 1'b0;
            bit_idx_q  <= 3'd0;
            stop_idx_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
// Directed testbench for uart_tx with CLK_FREQ=100, BIT_RATE=10 (10 clocks
// per bit). Three instances cover no parity/1 stop, even parity/1 stop and
// odd parity/2 stops; a shared FIFO model feeds whichever one is selected.
// ---------------------------------------------------------------------------
module tb_uart_tx;

    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] fifoData;
    logic       fifoEmpty0, fifoEmpty1, fifoEmpty2;
    logic       read0, read1, read2;
    logic       tx0, tx1, tx2;
    logic       busy0, busy1, busy2;

    logic       txSel, busySel, readSel;
    int         sel = 0;

    logic [7:0] mem [16];
    int         head = 0;
    int         tail = 0;
    int         popCount = 0;
    int         strayPops = 0;

    int         total = 0;
    int         bad = 0;

    logic       txLog   [0:255];
    logic       busyLog [0:255];
    logic       readLog [0:255];

    always #5 clk = ~clk;

    uart_tx #(.CLK_FREQ(100), .BIT_RATE(10), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifoEmpty0),
        .fifo_data(fifoData), .fifo_read(read0), .tx(tx0), .busy(busy0));

    uart_tx #(.CLK_FREQ(100), .BIT_RATE(10), .PARITY(2), .STOP_BITS(1)) dutEven (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifoEmpty1),
        .fifo_data(fifoData), .fifo_read(read1), .tx(tx1), .busy(busy1));

    uart_tx #(.CLK_FREQ(100), .BIT_RATE(10), .PARITY(1), .STOP_BITS(2)) dutOdd (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifoEmpty2),
        .fifo_data(fifoData), .fifo_read(read2), .tx(tx2), .busy(busy2));

    // The FIFO model is only visible to the selected instance; the others
    // always see an empty FIFO.
    assign fifoData   = mem[head % 16];
    assign fifoEmpty0 = (sel == 0) ? (head == tail) : 1'b1;
    assign fifoEmpty1 = (sel == 1) ? (head == tail) : 1'b1;
    assign fifoEmpty2 = (sel == 2) ? (head == tail) : 1'b1;

    always_comb begin
        case (sel)
            1:       begin txSel = tx1; busySel = busy1; readSel = read1; end
            2:       begin txSel = tx2; busySel = busy2; readSel = read2; end
            default: begin txSel = tx0; busySel = busy0; readSel = read0; end
        endcase
    end

    always @(posedge clk) begin
        if (readSel) begin
            head     <= head + 1;
            popCount <= popCount + 1;
        end
        if ((sel != 0 && read0) || (sel != 1 && read1) || (sel != 2 && read2)) begin
            strayPops <= strayPops + 1;
        end
    end

    // Expected line level idx clocks after the pop cycle (idx 0 = pop cycle).
    function automatic logic expTx(input logic [7:0] b, input int par, input int idx);
        int bitNo;
        if (idx < 1) return 1'b1;
        bitNo = (idx - 1) / CPB;
        if (bitNo == 0) return 1'b0;
        if (bitNo <= 8) return b[bitNo-1];
        if (par != 0 && bitNo == 9) return (par == 2) ? ^b : ~^b;
        return 1'b1;
    endfunction

    task automatic applyStimulus(input logic [7:0] b);
        mem[tail % 16] = b;
        tail = tail + 1;
    endtask

    task automatic waitPop(output bit found);
        #1;
        for (int w = 0; w < 50 && !readSel; w++) @(negedge clk);
        found      = readSel;
        txLog[0]   = txSel;
        busyLog[0] = busySel;
        readLog[0] = readSel;
    endtask

    task automatic recordCont(input int from, input int upto);
        for (int i = from; i <= upto; i++) begin
            @(negedge clk);
            txLog[i]   = txSel;
            busyLog[i] = busySel;
            readLog[i] = readSel;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b1;
        sel = 0;
        repeat (3) @(negedge clk);
        total++; if (tx0 !== 1'b1)   begin bad++; $display("[TB] FAIL reset_tx0 got=%b want=1", tx0); end
        total++; if (busy0 !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy0 got=%b want=0", busy0); end
        total++; if (read0 !== 1'b0) begin bad++; $display("[TB] FAIL reset_read0 got=%b want=0", read0); end
        total++; if (tx1 !== 1'b1 || tx2 !== 1'b1) begin bad++; $display("[TB] FAIL reset_tx_par got=%b%b want=11", tx1, tx2); end
        applyStimulus(8'h55);
        #1;
        total++; if (read0 !== 1'b0) begin bad++; $display("[TB] FAIL reset_priority_read got=%b want=0", read0); end
        @(negedge clk);
        total++; if (popCount !== 0) begin bad++; $display("[TB] FAIL reset_priority_pops got=%0d want=0", popCount); end
    endtask

    task automatic test_single();
        bit found;
        int errIdx, busyCnt, extraPops;
        reset = 1'b0;
        waitPop(found);
        total++; if (!found) begin bad++; $display("[TB] FAIL single_pop got=none want=pop"); end
        recordCont(1, 130);
        errIdx = -1; busyCnt = 0; extraPops = 0;
        for (int i = 0; i <= 130; i++) begin
            if (errIdx < 0 && txLog[i] !== expTx(8'h55, 0, i)) errIdx = i;
            if (busyLog[i] === 1'b1) busyCnt++;
            if (i > 0 && readLog[i] === 1'b1) extraPops++;
        end
        total++; if (errIdx >= 0) begin bad++; $display("[TB] FAIL single_wave idx=%0d got=%b want=%b", errIdx, txLog[errIdx], expTx(8'h55, 0, errIdx)); end
        total++; if (busyCnt !== 100) begin bad++; $display("[TB] FAIL single_busy got=%0d want=100", busyCnt); end
        total++; if (busyLog[1] !== 1'b1 || busyLog[101] !== 1'b0) begin bad++; $display("[TB] FAIL single_busy_edges got=%b%b want=10", busyLog[1], busyLog[101]); end
        total++; if (extraPops !== 0 || popCount !== 1) begin bad++; $display("[TB] FAIL single_pops got=%0d/%0d want=0/1", extraPops, popCount); end
    endtask

    task automatic test_empty_idle();
        int badRead = 0, badTx = 0, badBusy = 0;
        sel = 0;
        enable = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (read0 !== 1'b0) badRead++;
            if (tx0 !== 1'b1) badTx++;
            if (busy0 !== 1'b0) badBusy++;
        end
        total++; if (badRead !== 0) begin bad++; $display("[TB] FAIL empty_read cycles=%0d want=0", badRead); end
        total++; if (badTx !== 0)   begin bad++; $display("[TB] FAIL empty_tx cycles=%0d want=0", badTx); end
        total++; if (badBusy !== 0) begin bad++; $display("[TB] FAIL empty_busy cycles=%0d want=0", badBusy); end
    endtask

    task automatic test_back_to_back();
        bit found;
        int base, errIdx, firstLow;
        logic [7:0] b1, b2, want;
        base = popCount;
        applyStimulus(8'hA5);
        applyStimulus(8'h3C);
        waitPop(found);
        total++; if (!found) begin bad++; $display("[TB] FAIL b2b_pop got=none want=pop"); end
        recordCont(1, 215);
        errIdx = -1; firstLow = -1;
        for (int i = 0; i <= 215; i++) begin
            want = {7'd0, (i <= 101) ? expTx(8'hA5, 0, i) : expTx(8'h3C, 0, i - 101)};
            if (errIdx < 0 && txLog[i] !== want[0]) errIdx = i;
            if (i > 100 && firstLow < 0 && txLog[i] === 1'b0) firstLow = i;
        end
        for (int k = 0; k < 8; k++) begin
            b1[k] = txLog[16 + CPB*k];
            b2[k] = txLog[117 + CPB*k];
        end
        total++; if (errIdx >= 0) begin bad++; $display("[TB] FAIL b2b_wave idx=%0d got=%b", errIdx, txLog[errIdx]); end
        total++; if (popCount - base !== 2) begin bad++; $display("[TB] FAIL b2b_pops got=%0d want=2", popCount - base); end
        total++; if (readLog[101] !== 1'b1 || busyLog[101] !== 1'b0) begin bad++; $display("[TB] FAIL b2b_idle_pop got=%b/%b want=1/0", readLog[101], busyLog[101]); end
        total++; if (firstLow !== 102) begin bad++; $display("[TB] FAIL b2b_gap got=%0d want=102", firstLow); end
        total++; if (b1 !== 8'hA5) begin bad++; $display("[TB] FAIL b2b_byte1 got=%h want=a5", b1); end
        total++; if (b2 !== 8'h3C) begin bad++; $display("[TB] FAIL b2b_byte2 got=%h want=3c", b2); end
    endtask

    task automatic test_parity();
        bit found;
        int errIdx, busyCnt;
        int par, wantBusy;
        logic wantPar;
        for (int d = 1; d <= 2; d++) begin
            @(negedge clk);
            sel = d;
            par = (d == 1) ? 2 : 1;
            wantBusy = (d == 1) ? 110 : 120;
            wantPar = (d == 1) ? 1'b1 : 1'b0;
            applyStimulus(8'h07);
            waitPop(found);
            total++; if (!found) begin bad++; $display("[TB] FAIL parity_pop mode=%0d got=none want=pop", par); end
            recordCont(1, 130);
            errIdx = -1; busyCnt = 0;
            for (int i = 0; i <= 130; i++) begin
                if (errIdx < 0 && txLog[i] !== expTx(8'h07, par, i)) errIdx = i;
                if (busyLog[i] === 1'b1) busyCnt++;
            end
            total++; if (txLog[95] !== wantPar) begin bad++; $display("[TB] FAIL parity_bit mode=%0d got=%b want=%b", par, txLog[95], wantPar); end
            total++; if (busyCnt !== wantBusy) begin bad++; $display("[TB] FAIL parity_len mode=%0d got=%0d want=%0d", par, busyCnt, wantBusy); end
            total++; if (errIdx >= 0) begin bad++; $display("[TB] FAIL parity_wave mode=%0d idx=%0d got=%b", par, errIdx, txLog[errIdx]); end
        end
        @(negedge clk);
        sel = 0;
    endtask

    task automatic test_reset_midframe();
        bit found;
        int base, popMid, errIdx;
        base = popCount;
        applyStimulus(8'hF0);
        waitPop(found);
        total++; if (!found) begin bad++; $display("[TB] FAIL rstmid_pop got=none want=pop"); end
        recordCont(1, 35);
        reset = 1'b1;
        applyStimulus(8'h81);
        popMid = popCount;
        @(negedge clk);
        total++; if (tx0 !== 1'b1 || busy0 !== 1'b0 || read0 !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_outputs got=%b%b%b want=100", tx0, busy0, read0); end
        total++; if (popCount !== popMid || popCount - base !== 1) begin bad++; $display("[TB] FAIL rstmid_popcount got=%0d want=%0d", popCount - base, 1); end
        reset = 1'b0;
        waitPop(found);
        recordCont(1, 110);
        errIdx = -1;
        for (int i = 0; i <= 110; i++) if (errIdx < 0 && txLog[i] !== expTx(8'h81, 0, i)) errIdx = i;
        total++; if (!found || errIdx >= 0) begin bad++; $display("[TB] FAIL rstmid_next found=%0d idx=%0d", found, errIdx); end
        total++; if (popCount - base !== 2) begin bad++; $display("[TB] FAIL rstmid_pops got=%0d want=2", popCount - base); end
    endtask

    task automatic test_enable_drop();
        bit found;
        int base, errIdx, extraPops;
        base = popCount;
        enable = 1'b1;
        applyStimulus(8'h3C);
        applyStimulus(8'h99);
        waitPop(found);
        recordCont(1, 20);
        enable = 1'b0;
        recordCont(21, 140);
        errIdx = -1; extraPops = 0;
        for (int i = 0; i <= 140; i++) begin
            if (errIdx < 0 && txLog[i] !== expTx(8'h3C, 0, i)) errIdx = i;
            if (i > 0 && readLog[i] === 1'b1) extraPops++;
        end
        total++; if (!found || errIdx >= 0) begin bad++; $display("[TB] FAIL endrop_wave found=%0d idx=%0d", found, errIdx); end
        total++; if (extraPops !== 0 || popCount - base !== 1) begin bad++; $display("[TB] FAIL endrop_nopop got=%0d/%0d want=0/1", extraPops, popCount - base); end
        enable = 1'b1;
        #1;
        total++; if (read0 !== 1'b1) begin bad++; $display("[TB] FAIL endrop_resume got=%b want=1", read0); end
        waitPop(found);
        recordCont(1, 105);
        errIdx = -1;
        for (int i = 0; i <= 105; i++) if (errIdx < 0 && txLog[i] !== expTx(8'h99, 0, i)) errIdx = i;
        total++; if (!found || errIdx >= 0) begin bad++; $display("[TB] FAIL endrop_next found=%0d idx=%0d", found, errIdx); end
        total++; if (popCount - base !== 2) begin bad++; $display("[TB] FAIL endrop_pops got=%0d want=2", popCount - base); end
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        test_reset();
        test_single();
        test_empty_idle();
        test_back_to_back();
        test_parity();
        test_reset_midframe();
        test_enable_drop();
        total++; if (strayPops !== 0) begin bad++; $display("[TB] FAIL stray_pops got=%0d want=0", strayPops); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
